// File: rtl/skolem_pkg.sv
// Shared types and helpers for the Skolem evaluation arbiter: FSM states and
// the round-robin winner search.
package skolem_pkg;

   localparam int MIRROR_W = 20;
   localparam int MAX_REQ  = 8;
   localparam int PTR_W    = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic             found;
      logic [PTR_W-1:0] idx;
   } rr_pick_t;

   // First set bit of valid[n-1:0], scanning ptr, ptr+1, ... modulo n.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                        input logic [PTR_W-1:0]   ptr,
                                        input int                 n);
      rr_pick_t r;
      int       k;
      r = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         k = (int'(ptr) + i) % n;
         if (i < n && !r.found && valid[k]) begin
            r.found = 1'b1;
            r.idx   = PTR_W'(k);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/skolem_mirror_core.sv
// Combinational mirror Skolem function (y = x); any generated Skolem netlist
// with the same port shape can be dropped in here.
module skolem_mirror_core #(
   parameter int W = 20
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);

   assign y = x;

endmodule

// File: rtl/skolem_eval_arbiter.sv
// Round-robin front end that time-shares one Skolem core among N_REQ harnesses,
// registers each result, flags y != x, and keeps saturating pass/fail counters.
module skolem_eval_arbiter
   import skolem_pkg::*;
#(
   parameter int W     = MIRROR_W,
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_x,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [ID_W-1:0]    resp_id,
   output logic [W-1:0]       resp_y,
   output logic               resp_ok,
   input  logic               clr_cnt,
   output logic [CNT_W-1:0]   eval_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic               busy
);

   state_t           state, state_nxt;
   rr_pick_t         pick;
   logic [ID_W-1:0]  rr_ptr, id_q, grant_id;
   logic [N_REQ-1:0] grant_oh;
   logic [W-1:0]     x_q, core_y;
   logic             grant, resp_hs;

   assign pick = rr_pick(MAX_REQ'(req_valid), PTR_W'(rr_ptr), N_REQ);

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      grant_oh = '0;
      grant_id = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (int'(pick.idx) == k) begin
            grant_oh[k] = pick.found;
            grant_id    = ID_W'(k);
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      resp_valid = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            // rst_n gate keeps ready low while reset is held with requests pending.
            if (rst_n) req_ready = grant_oh;
            if (pick.found) state_nxt = EVAL;
         end
         EVAL: state_nxt = RESP;
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign grant   = (state == IDLE) && pick.found;
   assign resp_hs = resp_valid && resp_ready;

   skolem_mirror_core #(.W(W)) u_core (
      .x (x_q),
      .y (core_y)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         id_q    <= '0;
         rr_ptr  <= '0;
         resp_y  <= '0;
         resp_ok <= 1'b0;
         resp_id <= '0;
      end else begin
         if (grant) begin
            x_q  <= req_x[grant_id*W +: W];
            id_q <= grant_id;
         end
         if (state == EVAL) begin
            resp_y  <= core_y;
            resp_ok <= (core_y == x_q);
            resp_id <= id_q;
         end
         // Priority rotates past the requester just served.
         if (resp_hs) begin
            if (int'(id_q) == N_REQ-1) rr_ptr <= '0;
            else                       rr_ptr <= id_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eval_cnt <= '0;
         err_cnt  <= '0;
      end else if (clr_cnt) begin
         eval_cnt <= '0;
         err_cnt  <= '0;
      end else if (resp_hs) begin
         if (eval_cnt != '1)            eval_cnt <= eval_cnt + 1'b1;
         if (!resp_ok && err_cnt != '1) err_cnt  <= err_cnt + 1'b1;
      end
   end

endmodule

// File: doc/skolem_eval_arbiter.md
Name: skolem_eval_arbiter

Overview:
Shares one combinational 20-bit mirror Skolem core among N_REQ requesters.
- Round-robin arbitration; one evaluation in flight at a time.
- Each result is registered and checked against the mirror specification (y == x).
- Result is returned with the requester ID.
- Sits between the harnesses that drive candidate input vectors and the synthesized Skolem function. Keeps running pass/fail statistics for regression.

Parameters:
- W, 20, input/output vector width of the Skolem core.
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(N_REQ).
- CNT_W, 16, width of the evaluation and error counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_x  in  N_REQ*W  flattened input vectors; requester k occupies bits [k*W +: W].
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  ID_W  requester that owns the result.
- resp_y  out  W  Skolem output for the captured x.
- resp_ok  out  1  1 when resp_y == captured x.
- clr_cnt  in  1  synchronous clear of both counters.
- eval_cnt  out  CNT_W  completed responses, saturating.
- err_cnt  out  CNT_W  completed responses with resp_ok=0, saturating.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync deassert at the boundary):
  - FSM=IDLE, rr_ptr=0.
  - req_ready=0, resp_valid=0, resp_id=0, resp_y=0, resp_ok=0.
  - eval_cnt=0, err_cnt=0, busy=0.
  - Captured x/id registers cleared.
- FSM states are IDLE, EVAL and RESP.
- IDLE:
  - Winner g = first k with req_valid[k]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other ready bits are 0.
  - On that edge: x_q <= req_x[g], id_q <= g, go to EVAL.
  - No valid request: stay in IDLE, req_ready=0.
  - req_ready is never asserted outside IDLE.
- EVAL (exactly 1 cycle):
  - resp_y <= core(x_q).
  - resp_ok <= (core(x_q) == x_q).
  - resp_id <= id_q.
  - Go to RESP.
- RESP:
  - resp_valid=1. resp_y, resp_id and resp_ok stay stable until the handshake.
  - On resp_ready=1: go to IDLE and set rr_ptr <= (id_q+1) mod N_REQ. A new grant is possible the next cycle.
  - On resp_ready=0: hold indefinitely.
- Timing:
  - Latency: request accepted at edge t, resp_valid high from t+2.
  - Best-case throughput: one evaluation per 3 cycles.
- Fairness: a requester that holds req_valid is granted within N_REQ grants.
- Withdrawn request: dropping req_valid before its grant is legal and is not an error.
- Counters:
  - eval_cnt increments on each resp handshake.
  - err_cnt increments on each resp handshake with resp_ok=0.
  - Both saturate at 2^CNT_W-1.
  - When clr_cnt coincides with an increment, clear wins and the result is 0.
  - clr_cnt has no effect on the FSM.
- Reset mid-operation: the in-flight request is lost with no response. The requester must re-issue it.
- N_REQ=1: rr_ptr is constant 0.

Decomposition:
- Shared package skolem_pkg:
  - localparam MIRROR_W=20.
  - FSM state enum {IDLE, EVAL, RESP}, 2-bit encoding.
  - Function rr_pick(valid, ptr) returning the winner index and a found flag.
- Sub-module skolem_mirror_core:
  - Purely combinational, y = x, width W.
  - Instantiated once. It is replaceable by any generated Skolem netlist with the same port shape.
- Counters and arbiter stay inline.

Test Plan:
1. Single request: reset, then req_valid=4'b0001, req_x[0]=20'hABCDE, resp_ready=1.
   - Expect req_ready=4'b0001 in cycle 0 and resp_valid at cycle 2.
   - Expect resp_id=0, resp_y=20'hABCDE, resp_ok=1, eval_cnt=1, err_cnt=0.
2. Round-robin: all four req_valid held high.
   - Grants in order 0,1,2,3,0.
   - resp_id sequence 0,1,2,3,0, one response every 3 cycles.
3. Backpressure: resp_ready=0 for 10 cycles in RESP.
   - resp_valid, resp_y and resp_id stay stable; req_ready=0 throughout; busy=1.
   - Raise resp_ready: handshake, then IDLE next cycle.
4. Error detection: force the core output to x^20'h1 (fault-injected core), x=20'h00000.
   - Expect resp_y=20'h00001, resp_ok=0, err_cnt increments to 1.
5. Counter saturation and clear: CNT_W=4, 17 evaluations.
   - eval_cnt=15 after the 15th and holds at 15.
   - Assert clr_cnt in the same cycle as the 18th handshake: both counters read 0.
6. Reset mid-operation: assert rst_n=0 while in EVAL.
   - All outputs 0 immediately; no resp_valid after release.
   - The next request is granted starting from requester 0.
